// File: rtl/bs_pkg.sv
// Shared packet-size, SYNC, packet-type and PID-class definitions for the
// bit-stream decoder and encoder.
package bs_pkg;

  localparam int DATA_SIZE   = 88;
  localparam int TOKEN_SIZE  = 24;
  localparam int HSHAKE_SIZE = 8;
  localparam int CNT_W       = 7;

  localparam logic [7:0] SYNC = 8'b0000_0001;

  typedef enum logic [1:0] {
    PKT_NONE   = 2'b00,
    PKT_DATA   = 2'b01,
    PKT_TOKEN  = 2'b10,
    PKT_HSHAKE = 2'b11
  } pkt_type_e;

  // PID[1:0] class codes
  localparam logic [1:0] PID_SPECIAL = 2'b00;
  localparam logic [1:0] PID_TOKEN   = 2'b01;
  localparam logic [1:0] PID_HSHAKE  = 2'b10;
  localparam logic [1:0] PID_DATA    = 2'b11;

  // PKT_NONE means malformed: bad check nibble, special PID, or a PID whose
  // class disagrees with the received bit count.
  function automatic pkt_type_e classify(input logic [CNT_W-1:0] nbits,
                                         input logic [7:0]       pid);
    pkt_type_e t;
    t = PKT_NONE;
    if (pid[7:4] == ~pid[3:0]) begin
      case (pid[1:0])
        PID_TOKEN:  if (nbits == CNT_W'(TOKEN_SIZE))  t = PKT_TOKEN;
        PID_DATA:   if (nbits == CNT_W'(DATA_SIZE))   t = PKT_DATA;
        PID_HSHAKE: if (nbits == CNT_W'(HSHAKE_SIZE)) t = PKT_HSHAKE;
        default:    t = PKT_NONE;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/bs_decoder_sipo.sv
// Serial-in parallel-out shift register; new bits enter at the LSB.
module sipo_register #(
  parameter int WIDTH = 88
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             s_in,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= {q[WIDTH-2:0], s_in};
  end

endmodule

// File: rtl/bs_decoder.sv
// Packet decoder: checks SYNC, shifts in payload bits, classifies on EOP and
// holds the decoded packet until the protocol FSM acknowledges it.
module bs_decoder
  import bs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_start,
  input  logic        s_in,
  input  logic        s_valid,
  input  logic        rx_eop,
  input  logic        pkt_ack,
  output logic [1:0]  pkt_type,
  output logic [87:0] data,
  output logic [23:0] token,
  output logic [7:0]  hshake,
  output logic        pkt_valid,
  output logic        pkt_err,
  output logic        pkt_drop,
  output logic        free_inbound
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RECV,
    ST_DRAIN,
    ST_HOLD
  } state_e;

  state_e               state, state_nxt;
  pkt_type_e            held, held_nxt, cls;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_eff, pid_idx;
  logic [DATA_SIZE-1:0] sr, sr_eff;
  logic [7:0]           pid;
  logic                 sr_clr, sr_en, err_nxt, drop_nxt;

  sipo_register #(.WIDTH(DATA_SIZE)) u_sipo (
    .clk  (clk),
    .rst  (rst),
    .clr  (sr_clr),
    .en   (sr_en),
    .s_in (s_in),
    .q    (sr)
  );

  // View including this cycle's bit, so a bit coincident with EOP counts.
  assign sr_eff  = s_valid ? {sr[DATA_SIZE-2:0], s_in} : sr;
  assign cnt_eff = cnt + CNT_W'(s_valid);

  // PID is the oldest 8 bits, i.e. the top byte of the right-aligned payload.
  assign pid_idx = (cnt_eff >= CNT_W'(HSHAKE_SIZE) && cnt_eff <= CNT_W'(DATA_SIZE))
                   ? cnt_eff - CNT_W'(HSHAKE_SIZE) : '0;
  assign pid     = sr_eff[pid_idx +: 8];
  assign cls     = classify(cnt_eff, pid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      held     <= PKT_NONE;
      pkt_err  <= 1'b0;
      pkt_drop <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      held     <= held_nxt;
      pkt_err  <= err_nxt;
      pkt_drop <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    held_nxt  = held;
    sr_clr    = 1'b0;
    sr_en     = 1'b0;
    err_nxt   = 1'b0;
    drop_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        sr_clr  = 1'b1;
        cnt_nxt = '0;
        if (rx_start) state_nxt = ST_SYNC;
      end
      ST_SYNC, ST_RECV, ST_DRAIN: begin
        if (rx_start) begin
          // abort in flight and restart on the new packet
          err_nxt   = 1'b1;
          sr_clr    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = ST_SYNC;
        end else if (state == ST_SYNC) begin
          if (rx_eop) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end else if (s_valid) begin
            sr_en   = 1'b1;
            cnt_nxt = cnt_eff;
            if (cnt == CNT_W'(7)) begin
              if (sr_eff[7:0] == SYNC) begin
                sr_clr    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_RECV;
              end else begin
                state_nxt = ST_DRAIN;
              end
            end
          end
        end else if (state == ST_RECV) begin
          sr_en   = s_valid;
          cnt_nxt = cnt_eff;
          if (rx_eop) begin
            if (cls != PKT_NONE) begin
              held_nxt  = cls;
              state_nxt = ST_HOLD;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end
          end else if (s_valid && cnt == CNT_W'(DATA_SIZE)) begin
            state_nxt = ST_DRAIN;
          end
        end else begin
          if (rx_eop) begin
            err_nxt   = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (rx_start) drop_nxt = 1'b1;
        if (pkt_ack)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pkt_valid    = (state == ST_HOLD);
  assign free_inbound = (state == ST_IDLE);
  assign pkt_type     = pkt_valid ? held : PKT_NONE;
  assign data   = (pkt_valid && held == PKT_DATA)   ? sr : '0;
  assign token  = (pkt_valid && held == PKT_TOKEN)  ? sr[TOKEN_SIZE-1:0] : '0;
  assign hshake = (pkt_valid && held == PKT_HSHAKE) ? sr[HSHAKE_SIZE-1:0] : '0;

endmodule
